// File: rtl/logic_capture.sv
// Logic-analyzer capture engine: divided sample tick, 8-stage sequential trigger, sample stream out.
// Optional per-channel edge matching is enabled by defining LOGIC_CAPTURE_EDGE_TRIG_EN.
module logic_capture #(
  parameter int size    = 32,
  parameter int max_div = 32,
  parameter int saddr_w = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(max_div)-1:0] ckdiv,
  input  logic [size-1:0]            dinput,
  input  logic                       arm,
  input  logic                       abort,
  output logic                       armed,
  output logic                       triggered,
  output logic                       done,
  output logic                       ready,
  output logic                       overrun,
  output logic [size-1:0]            tdata,
  output logic                       tvalid,
  input  logic                       tready,
  input  logic [size-1:0]            trig_level1_mask,
  input  logic [size-1:0]            trig_level1_type,
  input  logic [size-1:0]            trig_level1_level,
  input  logic [size-1:0]            trig_level2_mask,
  input  logic [size-1:0]            trig_level2_type,
  input  logic [size-1:0]            trig_level2_level,
  input  logic [size-1:0]            trig_level3_mask,
  input  logic [size-1:0]            trig_level3_type,
  input  logic [size-1:0]            trig_level3_level,
  input  logic [size-1:0]            trig_level4_mask,
  input  logic [size-1:0]            trig_level4_type,
  input  logic [size-1:0]            trig_level4_level,
  input  logic [size-1:0]            trig_level5_mask,
  input  logic [size-1:0]            trig_level5_type,
  input  logic [size-1:0]            trig_level5_level,
  input  logic [size-1:0]            trig_level6_mask,
  input  logic [size-1:0]            trig_level6_type,
  input  logic [size-1:0]            trig_level6_level,
  input  logic [size-1:0]            trig_level7_mask,
  input  logic [size-1:0]            trig_level7_type,
  input  logic [size-1:0]            trig_level7_level,
  input  logic [size-1:0]            trig_level8_mask,
  input  logic [size-1:0]            trig_level8_type,
  input  logic [size-1:0]            trig_level8_level,
  input  logic [saddr_w-1:0]         post_trigger_count,
  input  logic [saddr_w-1:0]         buffer_size,
  output logic [saddr_w-1:0]         trigger_pos
);

  localparam int DIV_W = $clog2(max_div);
  localparam logic [saddr_w-1:0] ONE_A = saddr_w'(1);
  localparam logic [DIV_W-1:0]   ONE_D = DIV_W'(1);

  // One-hot so the status outputs come straight off state flops.
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ARMED = 4'b0010,
    S_TRIG  = 4'b0100,
    S_DONE  = 4'b1000
  } state_e;

  state_e state_q, state_d;

  logic [size-1:0] mask [8];
  logic [size-1:0] typ  [8];
  logic [size-1:0] lvl  [8];
  logic [size-1:0] chan_ok [8];

  assign mask = '{trig_level1_mask, trig_level2_mask, trig_level3_mask, trig_level4_mask,
                  trig_level5_mask, trig_level6_mask, trig_level7_mask, trig_level8_mask};
  assign typ  = '{trig_level1_type, trig_level2_type, trig_level3_type, trig_level4_type,
                  trig_level5_type, trig_level6_type, trig_level7_type, trig_level8_type};
  assign lvl  = '{trig_level1_level, trig_level2_level, trig_level3_level, trig_level4_level,
                  trig_level5_level, trig_level6_level, trig_level7_level, trig_level8_level};

  logic [DIV_W-1:0]   div_q, div_d;
  logic [saddr_w-1:0] idx_q, idx_d;
  logic [saddr_w-1:0] pc_q, pc_d;
  logic [saddr_w-1:0] tpos_q, tpos_d;
  logic [2:0]         stage_q, stage_d;
  logic [size-1:0]    tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;
  logic               overrun_q, overrun_d;

  logic       running, tick, abort_act, arm_act, sample_en, push;
  logic       any_cfg, fire, post_hit, post_last;
  logic [2:0] last_stage;
  logic [7:0] stage_match;

  assign running   = (state_q == S_ARMED) || (state_q == S_TRIG);
  assign tick      = running && (div_q == '0);
  assign abort_act = abort && running;
  assign arm_act   = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign sample_en = tick && !abort_act;
  assign post_hit  = pc_q >= post_trigger_count;
  assign post_last = (pc_q + ONE_A) == post_trigger_count;
  assign push      = sample_en && !((state_q == S_TRIG) && post_hit);

`ifdef LOGIC_CAPTURE_EDGE_TRIG_EN
  logic [size-1:0] prev_q;
  logic            prev_vld_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (arm_act) begin
      prev_vld_q <= 1'b0;
    end else if (sample_en) begin
      prev_q     <= dinput;
      prev_vld_q <= 1'b1;
    end
  end

  // Edge channels never match until a reference sample exists for this run.
  always_comb begin
    for (int s = 0; s < 8; s++) begin
      chan_ok[s] = (~typ[s] & ~(dinput ^ lvl[s]))
                 | (typ[s] & ((lvl[s] & ~prev_q & dinput) | (~lvl[s] & prev_q & ~dinput))
                           & {size{prev_vld_q}});
    end
  end
`else
  logic unused_type;
  assign unused_type = ^{typ[0], typ[1], typ[2], typ[3], typ[4], typ[5], typ[6], typ[7]};

  always_comb begin
    for (int s = 0; s < 8; s++) begin
      chan_ok[s] = ~(dinput ^ lvl[s]);
    end
  end
`endif

  // Unconfigured stages have an empty mask and so match vacuously (pass-through).
  always_comb begin
    last_stage = '0;
    any_cfg    = 1'b0;
    for (int s = 0; s < 8; s++) begin
      stage_match[s] = &(~mask[s] | chan_ok[s]);
      if (|mask[s]) begin
        last_stage = 3'(s);
        any_cfg    = 1'b1;
      end
    end
  end

  assign fire = sample_en && (state_q == S_ARMED) && stage_match[stage_q]
             && (!any_cfg || (stage_q == last_stage));

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (arm) state_d = S_ARMED;
      S_ARMED: begin
        if (abort)     state_d = S_IDLE;
        else if (fire) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (abort)                               state_d = S_IDLE;
        else if (tick && (post_hit || post_last)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = state_q[0];
    armed     = state_q[1];
    triggered = state_q[2];
    done      = state_q[3];
  end

  always_comb begin
    div_d     = div_q;
    idx_d     = idx_q;
    pc_d      = pc_q;
    tpos_d    = tpos_q;
    stage_d   = stage_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q && !tready;
    overrun_d = overrun_q;
    if (arm_act) begin
      div_d     = '0;
      idx_d     = '0;
      pc_d      = '0;
      tpos_d    = '0;
      stage_d   = '0;
      overrun_d = 1'b0;
    end
    if (running && !abort_act) div_d = (div_q == ckdiv) ? '0 : div_q + ONE_D;
    if (sample_en) idx_d = (idx_q == buffer_size - ONE_A) ? '0 : idx_q + ONE_A;
    if (sample_en && (state_q == S_ARMED) && stage_match[stage_q] && !fire) stage_d = stage_q + 3'd1;
    if (fire) begin
      tpos_d = idx_q;
      pc_d   = '0;
    end
    if (sample_en && (state_q == S_TRIG) && !post_hit) pc_d = pc_q + ONE_A;
    if (push) begin
      tdata_d  = dinput;
      tvalid_d = 1'b1;
      if (tvalid_q && !tready) overrun_d = 1'b1;
    end
    if (abort_act) tvalid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q     <= '0;
      idx_q     <= '0;
      pc_q      <= '0;
      tpos_q    <= '0;
      stage_q   <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      pc_q      <= pc_d;
      tpos_q    <= tpos_d;
      stage_q   <= stage_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign tdata       = tdata_q;
  assign tvalid      = tvalid_q;
  assign overrun     = overrun_q;
  assign trigger_pos = tpos_q;

endmodule

// File: tb/tb_logic_capture.sv
// Scoreboard bench for logic_capture: stimulus queues expected beats, a monitor pops them on handshake.
module tb_logic_capture;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ckdiv;
  logic [31:0] dinput;
  logic        arm, abort;
  logic        armed, triggered, done, ready, overrun;
  logic [31:0] tdata;
  logic        tvalid, tready;
  logic [31:0] m [8];
  logic [31:0] t [8];
  logic [31:0] l [8];
  logic [23:0] post_trigger_count, buffer_size, trigger_pos;

  int checks = 0;
  int failures = 0;
  int beats = 0;
  int b0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  logic_capture dut (
    .clk(clk), .reset(reset), .ckdiv(ckdiv), .dinput(dinput), .arm(arm), .abort(abort),
    .armed(armed), .triggered(triggered), .done(done), .ready(ready), .overrun(overrun),
    .tdata(tdata), .tvalid(tvalid), .tready(tready),
    .trig_level1_mask(m[0]), .trig_level1_type(t[0]), .trig_level1_level(l[0]),
    .trig_level2_mask(m[1]), .trig_level2_type(t[1]), .trig_level2_level(l[1]),
    .trig_level3_mask(m[2]), .trig_level3_type(t[2]), .trig_level3_level(l[2]),
    .trig_level4_mask(m[3]), .trig_level4_type(t[3]), .trig_level4_level(l[3]),
    .trig_level5_mask(m[4]), .trig_level5_type(t[4]), .trig_level5_level(l[4]),
    .trig_level6_mask(m[5]), .trig_level6_type(t[5]), .trig_level6_level(l[5]),
    .trig_level7_mask(m[6]), .trig_level7_type(t[6]), .trig_level7_level(l[6]),
    .trig_level8_mask(m[7]), .trig_level8_type(t[7]), .trig_level8_level(l[7]),
    .post_trigger_count(post_trigger_count), .buffer_size(buffer_size),
    .trigger_pos(trigger_pos)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // Monitor: every accepted beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && tvalid && tready) begin
      beats++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got %0h expected no beat", tdata);
      end else begin
        chk("beat_data", tdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; arm = 1'b0; abort = 1'b0; ckdiv = '0; dinput = '0; tready = 1'b1;
    post_trigger_count = '0; buffer_size = 24'd128;
    for (int i = 0; i < 8; i++) begin m[i] = '0; t[i] = '0; l[i] = '0; end
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("rst_ready", ready, 1);
    chk("rst_armed", armed, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_trigger_pos", trigger_pos, 0);

    // Immediate trigger: no stages configured, first tick triggers.
    post_trigger_count = 24'd10;
    b0 = beats;
    arm_pulse();
    for (int k = 0; k <= 10; k++) begin
      dinput = 32'hA000 + k;
      exp_q.push_back(dinput);
      step();
      if (k == 0) begin
        chk("imm_triggered", triggered, 1);
        chk("imm_trigger_pos", trigger_pos, 0);
      end
    end
    chk("imm_done", done, 1);
    step();
    chk("imm_tvalid_drop", tvalid, 0);
    chk("imm_beats", beats - b0, 11);

    // Level trigger on dinput[0]==1 at sample 20, then 2 post samples.
    m[0] = 32'h1; l[0] = 32'h1; post_trigger_count = 24'd2;
    arm_pulse();
    for (int k = 0; k <= 22; k++) begin
      dinput = (32'(k) << 4) | ((k >= 20) ? 32'h1 : 32'h0);
      exp_q.push_back(dinput);
      step();
      if (k == 5)  chk("lvl_armed", armed, 1);
      if (k == 19) chk("lvl_not_yet", triggered, 0);
      if (k == 20) begin
        chk("lvl_triggered", triggered, 1);
        chk("lvl_trigger_pos", trigger_pos, 20);
      end
    end
    chk("lvl_done", done, 1);

    // Two-stage sequence with index wrap at 8; post count 0.
    m[1] = 32'h2; l[1] = 32'h2; buffer_size = 24'd8; post_trigger_count = 24'd0;
    arm_pulse();
    for (int k = 0; k <= 9; k++) begin
      dinput = (32'(k) << 8) | ((k >= 9) ? 32'h2 : 32'h0) | ((k >= 5) ? 32'h1 : 32'h0);
      exp_q.push_back(dinput);
      step();
      if (k == 8) chk("seq_still_armed", armed, 1);
    end
    chk("seq_triggered", triggered, 1);
    chk("seq_trigger_pos", trigger_pos, 1);
    dinput = 32'hFFFF0000;
    step();
    chk("seq_done_post0", done, 1);
    step();
    chk("seq_tvalid_drop", tvalid, 0);

    // Overrun with stalled sink and ckdiv=3, then abort; arm while armed is ignored.
    m[1] = '0; l[1] = '0; buffer_size = 24'd128; dinput = '0; ckdiv = 5'd3; tready = 1'b0;
    arm_pulse();
    step();
    chk("ovr_tvalid_first", tvalid, 1);
    chk("ovr_none_yet", overrun, 0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    step();
    chk("ovr_before_tick2", overrun, 0);
    step();
    chk("ovr_set", overrun, 1);
    chk("ovr_tvalid_held", tvalid, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_tvalid", tvalid, 0);
    chk("ovr_sticky", overrun, 1);
    tready = 1'b1;
    step();
    step();
    // Re-arm clears overrun; abort on the first tick discards its sample.
    arm = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b1;
    chk("rearm_ovr_clear", overrun, 0);
    chk("rearm_armed", armed, 1);
    step();
    abort = 1'b0;
    chk("abort_tick_ready", ready, 1);
    chk("abort_tick_tvalid", tvalid, 0);

`ifdef LOGIC_CAPTURE_EDGE_TRIG_EN
    // Rising edge on dinput[1]: high at arm, falls, then rises at sample 3.
    m[0] = 32'h2; t[0] = 32'h2; l[0] = 32'h2; ckdiv = '0; post_trigger_count = '0;
    arm_pulse();
    for (int k = 0; k <= 3; k++) begin
      dinput = (32'(k) << 8) | ((k == 0 || k == 3) ? 32'h2 : 32'h0);
      exp_q.push_back(dinput);
      step();
      if (k == 0) chk("edge_no_first", triggered, 0);
      if (k == 2) chk("edge_no_fall", triggered, 0);
    end
    chk("edge_triggered", triggered, 1);
    chk("edge_trigger_pos", trigger_pos, 3);
    step();
    chk("edge_done", done, 1);
`endif

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/logic_capture.md
# logic_capture

Single-clock logic-analyzer capture engine. Samples a `size`-bit input bus at a programmable divided rate, runs an 8-stage sequential trigger, and streams every sample captured while armed to a downstream FIFO over an AXI-Stream-style master port. It reports trigger position and status so software can locate the trigger in a circular sample buffer.

## Interface
- `size`, 32: input channel count and sample width.
- `max_div`, 32: maximum clock divider; `ckdiv` width is `$clog2(max_div)`.
- `saddr_w`, 24: sample counter width.

- `clk`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `ckdiv`  in  `$clog2(max_div)`  sample tick every `ckdiv+1` clocks.
- `dinput`  in  `size`  channel inputs, already synchronous to `clk`.
- `arm`, `abort`  in  1  single-cycle commands.
- `armed`, `triggered`, `done`, `ready`  out  1  status, one-hot by state.
- `overrun`  out  1  sticky sample-loss flag.
- `tdata`  out  `size`; `tvalid`  out  1; `tready`  in  1: sample stream.
- `trig_levelN_mask`, `trig_levelN_type`, `trig_levelN_level`, N=1..8  in  `size`  trigger stage configuration.
- `post_trigger_count`  in  `saddr_w`  samples to take after the trigger.
- `buffer_size`  in  `saddr_w`  circular buffer length in samples; must be at least 1.
- `trigger_pos`  out  `saddr_w`  buffer index of the trigger sample.

## Operation
- **States:** IDLE (`ready`=1), ARMED (`armed`=1), TRIG (`triggered`=1), DONE (`done`=1).
- **Transitions:**
  - IDLE or DONE to ARMED on `arm`.
  - ARMED to TRIG when the final configured stage matches.
  - TRIG to DONE once `post_trigger_count` further samples have been pushed. A count of 0 goes to DONE on the tick after the trigger.
  - `abort` in ARMED or TRIG returns to IDLE. `abort` has priority over `arm` and over a trigger in the same cycle.
  - `arm` in ARMED or TRIG is ignored.
- **Sample tick:** a divider counter runs only in ARMED and TRIG. It is cleared on entry to ARMED. The first tick occurs on the first ARMED cycle.
- **Sample push:** on each tick, `dinput` is latched to `tdata` and `tvalid` is set. `tvalid` clears on `tvalid && tready`.
- **Overrun:** if a tick occurs while `tvalid` is still set and unaccepted, `overrun` is set and the new sample overwrites `tdata`. `overrun` clears only on `arm` or reset.
- **Sample index:** increments per tick and wraps from `buffer_size-1` to 0. It is cleared on `arm`.
- **Trigger stages:** stage N is configured when `trig_levelN_mask` is non-zero. The active sequence is stages 1..K, where K is the highest configured stage; an unconfigured stage below K is a pass-through that matches immediately.
- **Channel match:** a stage matches on a tick when every masked channel i satisfies:
  - `type[i]`=0: `dinput[i]==level[i]`.
  - `type[i]`=1 (edge): rising if `level[i]`=1, falling if `level[i]`=0, relative to the previous tick's sample.
  - The edge reference is invalid on the first tick after `arm`, so edges cannot match there.
- **Stage advance:** at most one stage advances per tick.
- **No stages configured:** if all masks are zero, the first tick triggers.
- **Trigger capture:** `trigger_pos` latches the sample index of the triggering sample. It holds until the next `arm`.

## Timing
- **Reset (`reset`=0):** state IDLE, `ready`=1, all other outputs 0, counters cleared.
- **Registered outputs:** every output is registered. A tick's sample appears on `tdata`/`tvalid` in the cycle following the tick. State flags change the cycle after the causing tick or command.
- **Handshake:** `tdata` is stable while `tvalid && !tready`. `tvalid` drops in IDLE and DONE once the last pending sample is accepted. An abort discards a pending sample immediately.

## Configuration
- `LOGIC_CAPTURE_EDGE_TRIG_EN`: when defined, edge matching per channel is supported as described.
- When undefined, `type` inputs are ignored, every masked channel uses level matching, and the previous-sample register is omitted.

## Test plan
- **Reset/idle:** hold `reset`=0 for 5 cycles, then release -> `ready`=1, other status 0, `tvalid`=0, `trigger_pos`=0.
- **Immediate trigger:** all masks 0, `ckdiv`=0, `buffer_size`=128, `post_trigger_count`=10, `tready`=1, pulse `arm` -> `triggered` and `trigger_pos`=0. After 10 further samples, `done`=1. 11 valid beats total.
- **Level trigger:** stage 1 mask=0x1, type=0, level=1. Drive `dinput`=0 for 20 cycles, then 1 -> `trigger_pos`=20.
- **Edge trigger (macro on):** stage 1 mask=0x2, type=0x2, level=0x2. `dinput[1]` high at arm, falls, then rises -> trigger only on the rising sample.
- **Sequence and wrap:** stage 1 = `dinput[0]`==1, stage 2 = `dinput[1]`==1, `buffer_size`=8. Assert bit 0 at sample 5 and bit 1 at sample 9 -> `trigger_pos`=1.
- **Overrun/abort:** `tready`=0 with `ckdiv`=3 -> `overrun`=1 on the second tick. Then pulse `abort` -> `ready`=1 and `tvalid`=0 next cycle.
